seq_divider: RTL and testbench

- Signed 32-bit multicycle divider feeding the HI/LO multiplexers of the datapath.
- Operands come from the A and B registers.
- Start/done handshake with the control unit, which stalls in a wait state until done.
- Remainder goes to HI, quotient to LO, with a divide-by-zero flag for the exception path.
- Restoring algorithm, one quotient bit per cycle, operating on operand magnitudes.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_abs_neg.sv | 12 +
 rtl/seq_divider.sv | 123 ++++++++++++
 tb/tb_seq_divider.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package seq_divider_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      FIX  = ST_FIX
   } state_t;

endpackage

// File: rtl/seq_divider_abs_neg.sv
// Combinational conditional two's-complement negate; with neg=x[MSB] it yields |x|.
module seq_divider_abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/seq_divider.sv
// Signed restoring divider, one quotient bit per cycle: remainder to hi, quotient to lo.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;

   logic [WIDTH-1:0] a_mag, b_mag, lo_fix, hi_fix;
   logic [WIDTH:0]   shifted, trial;

   seq_divider_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.x(a),     .neg(a[WIDTH-1]), .y(a_mag));
   seq_divider_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.x(b),     .neg(b[WIDTH-1]), .y(b_mag));
   seq_divider_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.x(quo_q), .neg(qneg_q),     .y(lo_fix));
   seq_divider_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.x(rem_q), .neg(rneg_q),     .y(hi_fix));

   // Magnitudes are unsigned WIDTH-bit, so |0x80000000| = 2^31 survives intact.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (b == '0) begin
                  dz_d = 1'b1;
               end else begin
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  qneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                  rneg_d  = a[WIDTH-1];
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            // A borrow out of the (WIDTH+1)-bit trial means the divisor did not fit.
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            lo_d    = lo_fix;
            hi_d    = hi_fix;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: fixed vectors, handshake corner cases, random vs. arithmetic model.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        start = 1'b0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   seq_divider #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .start(start),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // MIPS DIV semantics from plain 64-bit signed arithmetic (truncating division).
   function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                 output logic [31:0] mlo, output logic [31:0] mhi);
      longint sa, sb, q, r;
      sa  = longint'($signed(ma));
      sb  = longint'($signed(mb));
      q   = sa / sb;
      r   = sa - q * sb;
      mlo = q[31:0];
      mhi = r[31:0];
   endfunction

   // Waits for done after start was sampled `already` edges ago; returns edges from the start edge.
   task automatic wait_done(input int already, input logic [31:0] prev_lo, output int k);
      k = already;
      while (!done && k < 80) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 20) chk("lo_held_calc", lo, prev_lo);
         if (k == 32) chk("busy_calc", busy, 1);
      end
   endtask

   task automatic do_div(input logic [31:0] da, input logic [31:0] db,
                         output logic [31:0] rlo, output logic [31:0] rhi);
      int k;
      logic [31:0] plo;
      plo = lo;
      @(negedge clk);
      a = da; b = db; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", busy, 1);
      wait_done(0, plo, k);
      chk("latency", k, 33);
      chk("busy_at_done", busy, 0);
      chk("dz_at_done", div_zero, 0);
      rlo = lo;
      rhi = hi;
      @(posedge clk);
      #1 chk("done_one_cycle", done, 0);
   endtask

   initial begin
      vec_t vecs[11];
      logic [31:0] glo, ghi, elo, ehi, plo, phi;
      int k;

      vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2};
      vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE};
      vecs[2]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
      vecs[3]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2};
      vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
      vecs[5]  = '{32'd5,        32'd9,        32'd0,        32'd5};
      vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
      vecs[7]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF};
      vecs[8]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0};
      vecs[9]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
      vecs[10] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0};

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         do_div(vecs[i].a, vecs[i].b, glo, ghi);
         chk($sformatf("vec%0d_lo", i), glo, vecs[i].lo);
         chk($sformatf("vec%0d_hi", i), ghi, vecs[i].hi);
      end

      // Divide by zero: one-cycle flag, no done, results untouched.
      plo = lo; phi = hi;
      @(negedge clk);
      a = 32'd7; b = 32'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("dz_pulse", div_zero, 1);
      chk("dz_no_done", done, 0);
      chk("dz_busy", busy, 0);
      chk("dz_lo_kept", lo, plo);
      chk("dz_hi_kept", hi, phi);
      @(posedge clk);
      #1;
      chk("dz_cleared", div_zero, 0);
      chk("dz_no_done2", done, 0);
      chk("dz_busy2", busy, 0);

      // Start while busy is ignored.
      plo = lo;
      @(negedge clk);
      a = 32'd20; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      a = 32'd9; b = 32'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(10, plo, k);
      chk("ign_latency", k, 33);
      chk("ign_lo", lo, 32'd6);
      chk("ign_hi", hi, 32'd2);

      // Asynchronous reset mid-operation, then a normal operation.
      @(negedge clk);
      a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_hi", hi, 0);
      chk("mid_rst_lo", lo, 0);
      @(negedge clk);
      reset = 1'b0;
      do_div(32'd50, 32'd5, glo, ghi);
      chk("post_rst_lo", glo, 32'd10);
      chk("post_rst_hi", ghi, 32'd0);

      // Random operands against the arithmetic model.
      for (int i = 0; i < 25; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         case (i % 3)
            0: rb = $urandom;
            1: rb = 32'($signed(8'($urandom)));
            default: rb = $urandom_range(1, 1000);
         endcase
         if (rb == 32'd0) rb = 32'd3;
         model(ra, rb, elo, ehi);
         do_div(ra, rb, glo, ghi);
         chk($sformatf("rnd%0d_lo", i), glo, elo);
         chk($sformatf("rnd%0d_hi", i), ghi, ehi);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
